dbus_responder: RTL and testbench
=================================

DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 Parameter DEPTH, 256: number of 64-bit words in the backing store; power of two, 2..4096.
REQ-002 Parameter LATENCY, 2: cycles from request acceptance to data_ok; legal range 1..15.
REQ-003 Port clk  in  1: sole clock; all state updates on rising edge.
REQ-004 Port reset  in  1: asynchronous, active-low reset.
REQ-005 Port req_valid  in  1: requester holds a request.
REQ-006 Port req_addr  in  64: byte address.
REQ-007 Port req_size  in  3: msize_t access size (MSIZE1/2/4/8).
REQ-008 Port req_strobe  in  8: byte write enables; all-zero means read.
REQ-009 Port req_data  in  64: write data, byte lanes aligned to req_addr[2:0].
REQ-010 Port resp_addr_ok  out  1: request address accepted; asserted together with resp_data_ok.
REQ-011 Port resp_data_ok  out  1: one-cycle completion pulse.
REQ-012 Port resp_data  out  64: full read word; valid only while resp_data_ok=1, else 0.
REQ-013 Port resp_err  out  1: misaligned-access flag; valid only with resp_data_ok.

Function
REQ-014 FSM SHALL have states IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-015 IDLE with req_valid=1 at cycle T SHALL accept the request: latch nothing, load cnt=LATENCY-1, go BUSY.
REQ-016 BUSY with cnt!=0 SHALL decrement cnt.
REQ-017 BUSY with cnt==0 SHALL assert resp_addr_ok=resp_data_ok=1 in that cycle (cycle T+LATENCY) and return to IDLE on the next edge.
REQ-018 Requester SHALL hold req_* stable from acceptance through the data_ok cycle; the responder SHALL read req_* live in the data_ok cycle.
REQ-019 req_valid falling to 0 in BUSY SHALL abort: return to IDLE next edge, no write, no data_ok.
REQ-020 Word index SHALL be req_addr[3 +: log2(DEPTH)]; upper address bits ignored (wrap-around aliasing).
REQ-021 Read: resp_data SHALL equal the stored word at the index, combinationally, in the data_ok cycle.
REQ-022 Write: on the data_ok edge, each byte i with req_strobe[i]=1 SHALL be replaced by req_data byte i; other bytes unchanged; resp_data returns the pre-write word.
REQ-023 Back-to-back: req_valid=1 in the cycle after data_ok SHALL be accepted as a new request; minimum spacing is LATENCY+1 cycles.
REQ-024 resp_addr_ok, resp_data_ok, resp_data and resp_err SHALL be 0 outside the data_ok cycle.

Reset
REQ-025 reset=0 SHALL force IDLE, cnt=0 and all outputs to 0 immediately, including mid-BUSY; an in-flight write SHALL NOT occur.
REQ-026 Backing-store contents SHALL NOT be reset.

Configuration
REQ-027 With DBUS_RESP_MISALIGN_EN defined: an access with req_addr not aligned to req_size SHALL complete normally in timing but suppress the write, drive resp_data=0 and resp_err=1.
REQ-028 Without DBUS_RESP_MISALIGN_EN: resp_err SHALL be tied 0 and misaligned accesses SHALL proceed using the indexed word and strobes as given.

Structure
REQ-029 msize_t and strobe width constants SHALL come from package common; DEPTH/LATENCY defaults SHALL be constants in common.
REQ-030 Storage SHALL be a sub-module dbus_sram (one byte-enabled write port, one asynchronous read port); FSM and checks stay in dbus_responder.

Verification
REQ-031 LATENCY=2, read addr 0x10 holding 0x1122334455667788, valid at T -> data_ok only at T+2, resp_data=0x1122334455667788.
REQ-032 Write addr 0x08, strobe 0x0F, data 0xAAAAAAAABBBBBBBB over word 0x0 -> later read of 0x08 returns 0x00000000BBBBBBBB.
REQ-033 DEPTH=256, read addr 0x800 -> returns the word at addr 0x0 (wrap).
REQ-034 reset=0 one cycle after accepting a write of 0xFF.. to 0x18 -> outputs 0 immediately, FSM IDLE, later read of 0x18 shows old value.
REQ-035 Macro defined, MSIZE4 write at addr 0x02 -> data_ok at T+LATENCY, resp_err=1, resp_data=0, memory unchanged; macro undefined -> resp_err=0.
REQ-036 Two back-to-back reads, second valid the cycle after first data_ok -> data_ok pulses exactly LATENCY+1 cycles apart, never in consecutive cycles.

Source files
------------

// File: rtl/dbus_responder_pkg.sv
// Shared bus types, widths and default geometry for the data-bus responder.
// Build option: DBUS_RESP_MISALIGN_EN turns on misaligned-access trapping.
package common;
    localparam int XLEN         = 64;
    localparam int STRB_W       = XLEN / 8;
    localparam int DBUS_DEPTH   = 256;
    localparam int DBUS_LATENCY = 2;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dbus_state_t;

    function automatic logic is_misaligned(logic [2:0] a, msize_t s);
        logic m;
        m = 1'b0;
        case (s)
            MSIZE2:  m = a[0];
            MSIZE4:  m = |a[1:0];
            MSIZE8:  m = |a;
            default: m = 1'b0;
        endcase
        return m;
    endfunction
endpackage

// File: rtl/dbus_responder_if.sv
// Request/response bundle between a data-bus requester and the responder.
// Build option: none.
interface dbus_responder_if;
    import common::*;

    logic              req_valid;
    logic [XLEN-1:0]   req_addr;
    msize_t            req_size;
    logic [STRB_W-1:0] req_strobe;
    logic [XLEN-1:0]   req_data;
    logic              resp_addr_ok;
    logic              resp_data_ok;
    logic [XLEN-1:0]   resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, req_size, req_strobe, req_data,
        input  resp_addr_ok, resp_data_ok, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_strobe, req_data,
        output resp_addr_ok, resp_data_ok, resp_data, resp_err
    );
endinterface

// File: rtl/dbus_responder_sram.sv
// Word-wide backing store: byte-enabled sync write, async read, no reset.
// Build option: none.
module dbus_sram
    import common::*;
#(
    parameter int DEPTH = DBUS_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [STRB_W-1:0]        be,
    input  logic [XLEN-1:0]          wdata,
    output logic [XLEN-1:0]          rdata
);
    logic [XLEN-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (we && be[i]) begin
                mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];
endmodule

// File: rtl/dbus_responder.sv
// Fixed-latency data-bus responder: IDLE/BUSY FSM in front of dbus_sram.
// Build option: DBUS_RESP_MISALIGN_EN flags and blocks misaligned accesses.
module dbus_responder
    import common::*;
#(
    parameter int DEPTH   = DBUS_DEPTH,
    parameter int LATENCY = DBUS_LATENCY
) (
    input  logic             clk,
    input  logic             reset,
    dbus_responder_if.slave  bus
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    dbus_state_t     state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            done;
    logic            mis;
    logic            we;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] rdata;
    logic            unused_bits;

    // Upper address bits alias onto the store
    assign idx         = bus.req_addr[3 +: AW];
    assign unused_bits = ^{bus.req_addr, bus.req_size};

`ifdef DBUS_RESP_MISALIGN_EN
    assign mis = is_misaligned(bus.req_addr[2:0], bus.req_size);
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (!bus.req_valid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign we               = done & ~mis;
    assign bus.resp_addr_ok = done;
    assign bus.resp_data_ok = done;
    assign bus.resp_data    = (done && !mis) ? rdata : '0;
    assign bus.resp_err     = done & mis;

    dbus_sram #(
        .DEPTH (DEPTH)
    ) u_sram (
        .clk   (clk),
        .we    (we),
        .addr  (idx),
        .be    (bus.req_strobe),
        .wdata (bus.req_data),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: vector table plus reset/abort/b2b/misalign.
// Build option: DBUS_RESP_MISALIGN_EN selects the misaligned-access expectations.
module tb_dbus_responder;
    import common::*;

    localparam int LAT = 2;

    typedef struct {
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strb;
        logic [63:0] data;
        logic [63:0] exp;
        bit          chk;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;

    dbus_responder_if bus();

    dbus_responder #(
        .DEPTH   (256),
        .LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic xact(input logic [63:0] a, input msize_t s,
                        input logic [7:0] st, input logic [63:0] d,
                        output logic [63:0] rd, output logic re,
                        output logic rao, output int lat,
                        output bit leak);
        bus.req_valid  = 1'b1;
        bus.req_addr   = a;
        bus.req_size   = s;
        bus.req_strobe = st;
        bus.req_data   = d;
        rd   = '0;
        re   = 1'b0;
        rao  = 1'b0;
        lat  = 99;
        leak = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.resp_data_ok) begin
                rd  = bus.resp_data;
                re  = bus.resp_err;
                rao = bus.resp_addr_ok;
                lat = k;
                break;
            end
            if (bus.resp_addr_ok || bus.resp_err || bus.resp_data != '0)
                leak = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_strobe = '0;
    endtask

    vec_t        vecs [12];
    logic [63:0] rd;
    logic        re;
    logic        rao;
    int          lat;
    bit          leak;
    int          n;
    int          stamps [2];
    logic [63:0] datas [2];
    bit          switched;
    bit          seen;

    initial begin
        vecs[0]  = '{64'h000, MSIZE8, 8'hFF, 64'h0, 64'h0, 1'b0};
        vecs[1]  = '{64'h010, MSIZE8, 8'hFF, 64'h1122334455667788, 64'h0, 1'b0};
        vecs[2]  = '{64'h018, MSIZE8, 8'hFF, 64'h0123456789ABCDEF, 64'h0, 1'b0};
        vecs[3]  = '{64'h008, MSIZE8, 8'hFF, 64'h0, 64'h0, 1'b0};
        vecs[4]  = '{64'h010, MSIZE8, 8'h00, 64'h0, 64'h1122334455667788, 1'b1};
        vecs[5]  = '{64'h008, MSIZE8, 8'h0F, 64'hAAAAAAAABBBBBBBB, 64'h0, 1'b1};
        vecs[6]  = '{64'h008, MSIZE8, 8'h00, 64'h0, 64'h00000000BBBBBBBB, 1'b1};
        vecs[7]  = '{64'h000, MSIZE8, 8'hFF, 64'hCAFEF00D12345678, 64'h0, 1'b1};
        vecs[8]  = '{64'h800, MSIZE8, 8'h00, 64'h0, 64'hCAFEF00D12345678, 1'b1};
        vecs[9]  = '{64'h808, MSIZE8, 8'hF0, 64'h9988776600000000,
                     64'h00000000BBBBBBBB, 1'b1};
        vecs[10] = '{64'h008, MSIZE8, 8'h00, 64'h0, 64'h99887766BBBBBBBB, 1'b1};
        vecs[11] = '{64'h018, MSIZE8, 8'h00, 64'h0, 64'h0123456789ABCDEF, 1'b1};

        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_size   = MSIZE8;
        bus.req_strobe = '0;
        bus.req_data   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data_ok", 64'(bus.resp_data_ok), 64'h0);
        chk("rst_data", bus.resp_data, 64'h0);
        chk("rst_state", 64'(dut.state_q), 64'(IDLE));
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            xact(vecs[i].addr, vecs[i].size, vecs[i].strb, vecs[i].data,
                 rd, re, rao, lat, leak);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(LAT));
            chk($sformatf("v%0d_leak", i), 64'(leak), 64'h0);
            chk($sformatf("v%0d_aok", i), 64'(rao), 64'h1);
            chk($sformatf("v%0d_err", i), 64'(re), 64'h0);
            if (vecs[i].chk)
                chk($sformatf("v%0d_data", i), rd, vecs[i].exp);
        end

        // Reset lands in the data_ok cycle of a write
        bus.req_valid  = 1'b1;
        bus.req_addr   = 64'h18;
        bus.req_size   = MSIZE8;
        bus.req_strobe = 8'hFF;
        bus.req_data   = 64'hFFFFFFFFFFFFFFFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rstw_pre_ok", 64'(bus.resp_data_ok), 64'h1);
        reset = 1'b0;
        #1;
        chk("rstw_ok", 64'(bus.resp_data_ok), 64'h0);
        chk("rstw_aok", 64'(bus.resp_addr_ok), 64'h0);
        chk("rstw_data", bus.resp_data, 64'h0);
        chk("rstw_state", 64'(dut.state_q), 64'(IDLE));
        bus.req_valid  = 1'b0;
        bus.req_strobe = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        xact(64'h18, MSIZE8, 8'h00, 64'h0, rd, re, rao, lat, leak);
        chk("rstw_read", rd, 64'h0123456789ABCDEF);

        // Abort: valid drops while BUSY
        bus.req_valid  = 1'b1;
        bus.req_addr   = 64'h10;
        bus.req_strobe = 8'hFF;
        bus.req_data   = 64'hDEADBEEFDEADBEEF;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_strobe = '0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.resp_data_ok) seen = 1'b1;
        end
        chk("abort_no_ok", 64'(seen), 64'h0);
        chk("abort_state", 64'(dut.state_q), 64'(IDLE));
        @(posedge clk);
        #1;
        xact(64'h10, MSIZE8, 8'h00, 64'h0, rd, re, rao, lat, leak);
        chk("abort_read", rd, 64'h1122334455667788);

        // Back-to-back reads
        bus.req_valid  = 1'b1;
        bus.req_addr   = 64'h10;
        bus.req_strobe = '0;
        n = 0;
        switched = 1'b0;
        stamps[0] = 0;
        stamps[1] = 0;
        datas[0]  = '0;
        datas[1]  = '0;
        for (int k = 0; k < 20 && n < 2; k++) begin
            @(negedge clk);
            if (bus.resp_data_ok) begin
                stamps[n] = cyc;
                datas[n]  = bus.resp_data;
                n++;
            end
            @(posedge clk);
            #1;
            if (n == 1 && !switched) begin
                bus.req_addr = 64'h18;
                switched = 1'b1;
            end
        end
        bus.req_valid = 1'b0;
        chk("b2b_count", 64'(n), 64'h2);
        chk("b2b_gap", 64'(stamps[1] - stamps[0]), 64'(LAT + 1));
        chk("b2b_d0", datas[0], 64'h1122334455667788);
        chk("b2b_d1", datas[1], 64'h0123456789ABCDEF);

        // Misaligned MSIZE4 write over word 0
        @(posedge clk);
        #1;
        xact(64'h02, MSIZE4, 8'h0F, 64'h5555555555555555,
             rd, re, rao, lat, leak);
        chk("mis_lat", 64'(lat), 64'(LAT));
`ifdef DBUS_RESP_MISALIGN_EN
        chk("mis_err", 64'(re), 64'h1);
        chk("mis_data", rd, 64'h0);
        xact(64'h00, MSIZE8, 8'h00, 64'h0, rd, re, rao, lat, leak);
        chk("mis_mem", rd, 64'hCAFEF00D12345678);
`else
        chk("mis_err", 64'(re), 64'h0);
        chk("mis_data", rd, 64'hCAFEF00D12345678);
        xact(64'h00, MSIZE8, 8'h00, 64'h0, rd, re, rao, lat, leak);
        chk("mis_mem", rd, 64'hCAFEF00D55555555);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
